// File: rtl/bitwise_shift_unit_if.sv
// Request/response bundle for bitwise_shift_unit: valid/ready operation input
// and valid/ready double-width result output.
interface bitwise_shift_unit_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op_sel;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;

    modport master (
        output in_valid, op_sel, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op_sel, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/bitwise_shift_unit.sv
// Handshaked logic/shift unit: one-cycle logic ops and ABS, serial shifts one bit per cycle.
// Define BITWISE_ROTATE_EN to enable opcode 111 (ROL); otherwise 111 returns zero.
module bitwise_shift_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(2*WIDTH)+1
) (
    input logic                clk,
    input logic                rst_n,
    bitwise_shift_unit_if.slave bus
);
    localparam int XW = 2*WIDTH;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_ABS = 3'b110;
`ifdef BITWISE_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'b111;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(XW);
    localparam logic [WIDTH-1:0] B_LIMIT  = WIDTH'(XW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state_r, state_nx_s;
    logic [XW-1:0]    acc_r, acc_nx_s, load_s, step_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s, amt_s;
    logic [2:0]       op_r, op_nx_s;
    logic             serial_s;
    logic             accept_s;
    logic             in_ready_r, out_valid_r, busy_r;

    function automatic logic [XW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    assign accept_s = bus.in_valid & in_ready_r;

    // Decode the incoming opcode into accumulator preload and serial step count.
    always_comb begin
        load_s   = {XW{1'b0}};
        amt_s    = CNT_ZERO;
        serial_s = 1'b0;
        case (bus.op_sel)
            OP_AND: load_s = sext(bus.a & bus.b);
            OP_OR:  load_s = sext(bus.a | bus.b);
            OP_XOR: load_s = sext(bus.a ^ bus.b);
            OP_NOT: load_s = sext(~bus.a);
            OP_SHL, OP_SHR: begin
                load_s   = sext(bus.a);
                amt_s    = (bus.b >= B_LIMIT) ? CNT_MAX : CNT_W'(bus.b);
                serial_s = 1'b1;
            end
            // Negation happens at double width, so the most negative input cannot overflow.
            OP_ABS: load_s = bus.a[WIDTH-1] ? ({XW{1'b0}} - sext(bus.a)) : sext(bus.a);
`ifdef BITWISE_ROTATE_EN
            OP_ROL: begin
                load_s   = {{WIDTH{1'b0}}, bus.a};
                amt_s    = CNT_W'(bus.b[$clog2(WIDTH)-1:0]);
                serial_s = 1'b1;
            end
`endif
            default: begin
                load_s   = {XW{1'b0}};
                amt_s    = CNT_ZERO;
                serial_s = 1'b0;
            end
        endcase
    end

    // One-bit step of the accumulator for the latched serial opcode.
    always_comb begin
        step_s = acc_r;
        case (op_r)
            OP_SHL: step_s = {acc_r[XW-2:0], 1'b0};
            OP_SHR: step_s = {acc_r[XW-1], acc_r[XW-1:1]};
`ifdef BITWISE_ROTATE_EN
            OP_ROL: step_s = {{WIDTH{1'b0}}, acc_r[WIDTH-2:0], acc_r[WIDTH-1]};
`endif
            default: step_s = acc_r;
        endcase
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        cnt_nx_s   = cnt_r;
        op_nx_s    = op_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    op_nx_s    = bus.op_sel;
                    acc_nx_s   = load_s;
                    cnt_nx_s   = amt_s;
                    state_nx_s = (serial_s && (amt_s != CNT_ZERO)) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_nx_s = step_s;
                cnt_nx_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Accumulator, step counter and latched opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {XW{1'b0}};
            cnt_r <= CNT_ZERO;
            op_r  <= 3'b000;
        end else begin
            acc_r <= acc_nx_s;
            cnt_r <= cnt_nx_s;
            op_r  <= op_nx_s;
        end
    end

    // Handshake flags registered from the next state so they align with state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.result    = acc_r;

endmodule

// File: doc/bitwise_shift_unit.md
# bitwise_shift_unit

Parametrised, handshaked successor to the calculator's combinational bitwise unit. Accepts one operation per transaction on a valid/ready input port, computes logic ops in one cycle and shifts/rotates serially one bit position per cycle, and presents a sign-correct double-width result on a valid/ready output port. It sits between the operand/opcode decoder and the result multiplexer of the calculator datapath.

## Interface
- `WIDTH`, 16: operand width in bits. Must be a power of two, ≥4.
- `CNT_W`, $clog2(2*WIDTH)+1: internal shift-counter width. Derived; do not override.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `op_sel` in 3: opcode, sampled on accept.
- `a` in WIDTH: signed operand A, sampled on accept.
- `b` in WIDTH: signed operand B / shift amount, sampled on accept.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream consumes result.
- `result` out 2*WIDTH: signed result, held stable while out_valid=1.
- `busy` out 1: high in SHIFT or DONE.

## Operation
- Accept = in_valid & in_ready at a rising edge. Opcode and operands are registered and then ignored until next accept.
- FSM states: IDLE → (accept) → SHIFT if serial op with n>0, else DONE; SHIFT → DONE when counter reaches 1 and is decremented to 0; DONE → IDLE on out_valid & out_ready.
- Opcodes; all results are 2*WIDTH, sign-extended from WIDTH unless noted:
  - 000 AND, 001 OR, 010 XOR: a op b. 011 NOT: ~a.
  - 100 SHL: sext(a) shifted left by n, zero fill. 101 SHR: sext(a) arithmetic right by n, sign fill.
  - 110 ABS: |a| computed in 2*WIDTH; a = −2^(WIDTH−1) gives +2^(WIDTH−1), with no overflow.
  - 111 ROL (macro-gated): a rotated left within WIDTH bits by n; result zero-extended.
- Shift amount: b is treated as unsigned. For SHL/SHR, n = min(b, 2*WIDTH), so b ≥ 2*WIDTH gives 0 for SHL and all-sign for SHR. For ROL, n = b mod WIDTH.
- Accumulator load on accept:
  - SHL/SHR: sext(a). ROL: zext(a). Logic ops/ABS: final result.
  - Each SHIFT cycle shifts or rotates the accumulator by 1 and decrements the counter.
- `result` = accumulator. It is valid only while out_valid=1 and holds its value under backpressure.

## Timing
- Reset values: state IDLE; in_ready=1; out_valid=0; busy=0; result=0; counter=0.
- Latency from accept edge to out_valid high:
  - 1 cycle for logic ops, ABS, and shifts/rotates with n=0.
  - 1+n cycles for shifts/rotates with n>0. Maximum is 1+2*WIDTH.
- in_ready falls in the cycle after accept. It returns high the cycle after the out handshake, so there is no back-to-back overlap. Throughput is one op per latency+1 cycles minimum.
- out_valid stays high until out_ready=1. A stalled DONE holds result and keeps in_ready=0.
- in_valid during SHIFT/DONE is ignored and never queued.
- rst_n low at any time, including mid-SHIFT, immediately forces reset values. The in-flight op is discarded and produces no out_valid.

## Configuration
- `BITWISE_ROTATE_EN` defined: opcode 111 = ROL as above.
- `BITWISE_ROTATE_EN` undefined:
  - Opcode 111 completes in 1 cycle with result=0, matching the legacy default.
  - No rotate datapath is synthesised.

## Test plan
- Reset, then WIDTH=16, op 000, a=16'h00F0, b=16'h0FF0 → out_valid 1 cycle after accept, result=32'h000000F0.
- Op 100, a=−3 (16'hFFFD), b=4 → out_valid 5 cycles after accept, result=32'hFFFFFFD0. Op 101, a=16'h8000, b=40 → 33 cycles, result=32'hFFFFFFFF.
- Op 110, a=16'h8000 → result=32'h00008000. Op 011, a=16'h00FF → result=32'hFFFFFF00.
- With macro defined: op 111, a=16'h8001, b=17 (n=1) → 2 cycles, result=32'h00000003. Without macro: result=0 after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles. Result is stable, in_ready=0, and a pulse on in_valid is ignored. Raise out_ready → IDLE next cycle.
- Assert rst_n=0 mid-SHL (b=20, cycle 7) → all outputs return to reset values immediately. No out_valid follows the release of reset.
